// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : word-wide data-memory initiator with read-modify-write sub-word stores
// Revision 1.0
// ============================================================================
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_data
);
   localparam logic [1:0] C_SIZE_BYTE    = 2'b00;
   localparam logic [1:0] C_SIZE_HALF    = 2'b01;
   localparam logic [1:0] C_SIZE_WORD    = 2'b10;
   localparam logic [1:0] C_SIZE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_write;
   logic        r_unsigned;
   logic        r_error;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rword;
   logic [31:0] r_rdata;

   logic        w_accept;
   logic        w_req_error;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_data;
   logic [31:0] w_word_address;

   assign w_accept       = req_valid && (r_state == S_IDLE);
   assign w_req_error    = (req_size == C_SIZE_ILLEGAL)
                        || ((req_size == C_SIZE_HALF) && req_addr[0])
                        || ((req_size == C_SIZE_WORD) && (req_addr[1:0] != 2'b00));
   assign w_word_address = {r_addr[31:2], 2'b00};

   // Extraction uses the live read data so the load result registers on the READ edge.
   always_comb begin
      w_byte      = 8'h00;
      w_half      = 16'h0000;
      w_load_data = mem_read_data;
      case (r_addr[1:0])
         2'd0:    w_byte = mem_read_data[7:0];
         2'd1:    w_byte = mem_read_data[15:8];
         2'd2:    w_byte = mem_read_data[23:16];
         default: w_byte = mem_read_data[31:24];
      endcase
      w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (r_size)
         C_SIZE_BYTE: w_load_data = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
         C_SIZE_HALF: w_load_data = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
         default:     w_load_data = mem_read_data;
      endcase
   end

   always_comb begin
      w_merge_data = r_rword;
      case (r_size)
         C_SIZE_BYTE: begin
            case (r_addr[1:0])
               2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
               2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
               2'd2:    w_merge_data[23:16] = r_wdata[7:0];
               default: w_merge_data[31:24] = r_wdata[7:0];
            endcase
         end
         C_SIZE_HALF: begin
            if (r_addr[1]) w_merge_data[31:16] = r_wdata[15:0];
            else           w_merge_data[15:0]  = r_wdata[15:0];
         end
         default: w_merge_data = r_wdata;
      endcase
   end

   always_comb begin
      w_next           = r_state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      mem_address      = 32'h0000_0000;
      mem_write_data   = 32'h0000_0000;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_req_error)                                 w_next = S_RESP;
               else if (req_write && (req_size == C_SIZE_WORD)) w_next = S_WRITE;
               else                                             w_next = S_READ;
            end
         end
         S_READ: begin
            mem_read_enable = 1'b1;
            mem_address     = w_word_address;
            w_next          = r_write ? S_WRITE : S_RESP;
         end
         S_WRITE: begin
            mem_write_enable = 1'b1;
            mem_address      = w_word_address;
            mem_write_data   = w_merge_data;
            w_next           = S_RESP;
         end
         default: begin
            resp_valid = 1'b1;
            w_next     = S_IDLE;
         end
      endcase
   end

   assign resp_rdata = r_rdata;
   assign resp_error = r_error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_unsigned <= 1'b0;
         r_error    <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= 32'h0000_0000;
         r_wdata    <= 32'h0000_0000;
         r_rword    <= 32'h0000_0000;
         r_rdata    <= 32'h0000_0000;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_write    <= req_write;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_error    <= w_req_error;
                  r_rdata    <= 32'h0000_0000;
               end
            end
            S_READ: begin
               r_rword <= mem_read_data;
               if (!r_write) r_rdata <= w_load_data;
            end
            S_RESP: begin
               r_error <= 1'b0;
               r_rdata <= 32'h0000_0000;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the single-cycle processor's data memory. Accepts one load or store request from the execute stage, issues the word-wide `address`/`write_data`/`write_enable`/`read_enable` transaction to `DataMemory`, and returns load data or completion. Handles byte and halfword accesses: loads are sign- or zero-extended, and sub-word stores use a read-modify-write sequence. Misaligned requests are flagged.

## Interface

- No parameters: data and address are fixed at 32 bits.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit idle; a request is accepted when both `req_valid` and `req_ready` are high at a clock edge.
- `req_write`  input  1  1 = store, 0 = load.
- `req_size`  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  input  1  loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data, right-aligned.
- `resp_valid`  output  1  one-cycle completion pulse.
- `resp_rdata`  output  32  extended load data; 0 for stores and errors.
- `resp_error`  output  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_address`  output  32  word-aligned byte address; bits [1:0] are always 0.
- `mem_write_data`  output  32  word written to memory.
- `mem_write_enable`  output  1  memory writes on the rising edge while this is high.
- `mem_read_enable`  output  1  read strobe.
- `mem_read_data`  input  32  combinational read data for `mem_address`; valid in the same cycle as `mem_read_enable`.

## Operation

- **Latched fields:** on acceptance the unit registers `write`, `size`, `unsigned`, `addr` and `wdata`. Request inputs are ignored outside IDLE.
- **Error check:** a request is in error when any of these hold:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - size 11.
- **IDLE:** `req_ready`=1. On acceptance the next state is chosen as follows:
  - error → RESP;
  - load, or byte/half store → READ;
  - word store → WRITE.
- **READ:** `mem_read_enable`=1 and `mem_address`={addr[31:2],2'b00}. `mem_read_data` is captured into `rword` at the edge.
  - Load → RESP, with `resp_rdata` registered from the extracted lane.
  - Store → WRITE.
- **Extraction:**
  - byte = `rword` lane `addr[1:0]`, i.e. bits [8k+7:8k];
  - half = lane `addr[1]`, i.e. bits [16h+15:16h];
  - the result is extended to 32 bits per `unsigned`;
  - word is passed through.
- **WRITE:** `mem_write_enable`=1 for exactly one cycle, with `mem_address` as in READ. Next state is RESP. `mem_write_data` is:
  - word: `wdata`;
  - byte: `rword` with lane `addr[1:0]` replaced by `wdata[7:0]`;
  - half: `rword` with lane `addr[1]` replaced by `wdata[15:0]`.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE. There is no response backpressure.
- **Idle drive values:** outside READ/WRITE, `mem_address`, `mem_write_data` and both enables are 0. `mem_read_enable` and `mem_write_enable` are never high together.
- **Error requests** produce no memory activity.

## Timing

- Cycle 0 is the acceptance edge. `resp_valid` is high in the following cycle:
  - error: cycle 1;
  - word store: cycle 2 (write edge ends cycle 1);
  - load: cycle 2;
  - byte/half store: cycle 3 (read in cycle 1, write in cycle 2).
- `req_ready` is low from the cycle after acceptance through RESP. It returns high the cycle after `resp_valid`, so back-to-back requests are spaced by the latencies above.
- **Reset values:** while `rst_n` is low, state = IDLE and:
  - `req_ready`=1;
  - `resp_valid`, `resp_error`, `resp_rdata` = 0;
  - all `mem_*` outputs = 0.
  - `rword` and the latched fields = 0.
- **Reset mid-operation:** the transaction is abandoned with no response.
  - Reset during READ of a sub-word store: no write occurs and the memory word is unchanged.
  - Reset asserted in WRITE before the edge: the write is suppressed because the enable is forced to 0 asynchronously.

## Test plan

- **Word store, then load:** word store of 0xABCDEFFF to 0x10 → `mem_write_enable` high in cycle 1 only, `resp_valid` in cycle 2 with `resp_error`=0. Word load of 0x10 → `resp_rdata`=0xABCDEFFF in cycle 2.
- **Byte store RMW:** byte store of 0x12 to 0x11 over 0xABCDEFFF → read cycle 1, write cycle 2 with `mem_write_data`=0xABCD12FF at `mem_address` 0x10, `resp_valid` cycle 3. Half store of 0x5566 to 0x12 → 0x556612FF.
- **Extension:** memory word 0x80FF7F80 at 0x20. Signed byte load from 0x20 → 0xFFFFFF80; unsigned → 0x00000080. Signed half load from 0x22 → 0xFFFF80FF; unsigned → 0x000080FF.
- **Errors:** half load from 0x11, word store to 0x22 and size 11 → each gives `resp_error`=1 and `resp_rdata`=0 in cycle 1, with both memory enables low throughout.
- **Reset during RMW:** `rst_n` pulled low in the READ cycle of a byte store to 0x10 → no `mem_write_enable`, memory word unchanged, `req_ready`=1 and all other outputs 0 immediately. A new request after release completes normally.
- **Back-to-back:** `req_valid` held high with a queue of mixed requests → each accepted only when `req_ready`=1, with exactly one `resp_valid` per request in order.
